controlador_varredura_display: RTL and testbench

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It owns one shared 4-bit-to-7-segment decoder and drives it with one digit nibble at a time. In step with that, it drives the active-low anode lines and the decimal point. It sits between the datapath that produces a packed hexadecimal value and the decoder plus the board's display pins.

---
 rtl/controlador_varredura_display.sv | 137 +++++++++++++
 tb/tb_controlador_varredura_display.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_varredura_display.sv
// rtl/controlador_varredura_display.sv - time-multiplexed scan controller for an N-digit common-anode 7-segment display
module controlador_varredura_display #(
    parameter int N_DIGITOS    = 4,
    parameter int CICLOS_EXIBE = 50000,
    parameter int CICLOS_APAGA = 500,
    localparam int IW          = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic                   carregar,
    input  logic [4*N_DIGITOS-1:0] valor_in,
    input  logic [N_DIGITOS-1:0]   pontos_in,
    input  logic                   apagar_zeros,
    output logic [3:0]             digito_bcd,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic                   ponto,
    output logic [IW-1:0]          indice,
    output logic                   quadro_fim
);
    localparam int CMAX = (CICLOS_EXIBE > CICLOS_APAGA) ? CICLOS_EXIBE : CICLOS_APAGA;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] CNT_APAGA = CW'(CICLOS_APAGA);
    localparam logic [CW-1:0] CNT_EXIBE = CW'(CICLOS_EXIBE);
    localparam logic [CW-1:0] CNT_UM    = CW'(1);
    localparam logic [IW-1:0] IDX_ULT   = IW'(N_DIGITOS - 1);

    typedef enum logic [1:0] {OCIOSO, APAGA, EXIBE} estado_t;

    estado_t                estado, estado_prox;
    logic [CW-1:0]          cnt, cnt_prox;
    logic [IW-1:0]          idx_prox;
    logic                   copia;
    logic [4*N_DIGITOS-1:0] pend_valor, ativo_valor, ativo_valor_prox;
    logic [N_DIGITOS-1:0]   pend_pontos, ativo_pontos, ativo_pontos_prox;
    logic [N_DIGITOS-1:0]   suprimido;
    logic [N_DIGITOS-1:0]   anodos_d;
    logic                   ponto_d, quadro_d, todos_zero;
    logic [3:0]             digito_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            indice       <= '0;
            pend_valor   <= '0;
            pend_pontos  <= '0;
            ativo_valor  <= '0;
            ativo_pontos <= '0;
            anodos       <= '1;
            ponto        <= 1'b1;
            digito_bcd   <= 4'd0;
            quadro_fim   <= 1'b0;
        end else begin
            estado       <= estado_prox;
            cnt          <= cnt_prox;
            indice       <= idx_prox;
            ativo_valor  <= ativo_valor_prox;
            ativo_pontos <= ativo_pontos_prox;
            anodos       <= anodos_d;
            ponto        <= ponto_d;
            digito_bcd   <= digito_d;
            quadro_fim   <= quadro_d;
            if (carregar) begin
                pend_valor  <= valor_in;
                pend_pontos <= pontos_in;
            end
        end
    end

    // ativo only takes pendente at a frame start, so a frame never mixes values
    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        idx_prox    = indice;
        copia       = 1'b0;
        case (estado)
            OCIOSO: begin
                if (habilita) begin
                    idx_prox    = '0;
                    copia       = 1'b1;
                    cnt_prox    = CNT_APAGA;
                    estado_prox = APAGA;
                end
            end
            APAGA: begin
                if (cnt <= CNT_UM) begin
                    cnt_prox    = CNT_EXIBE;
                    estado_prox = EXIBE;
                end else begin
                    cnt_prox = cnt - CNT_UM;
                end
            end
            EXIBE: begin
                if (cnt <= CNT_UM) begin
                    cnt_prox    = CNT_APAGA;
                    estado_prox = APAGA;
                    if (indice == IDX_ULT) begin
                        idx_prox = '0;
                        copia    = 1'b1;
                    end else begin
                        idx_prox = indice + 1'b1;
                    end
                end else begin
                    cnt_prox = cnt - CNT_UM;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
        if (!habilita) begin
            estado_prox = OCIOSO;
            cnt_prox    = '0;
            idx_prox    = '0;
            copia       = 1'b0;
        end
        ativo_valor_prox  = copia ? pend_valor  : ativo_valor;
        ativo_pontos_prox = copia ? pend_pontos : ativo_pontos;
    end

    // outputs are decoded from next-state values and then registered
    always_comb begin
        todos_zero = 1'b1;
        suprimido  = '0;
        for (int k = N_DIGITOS - 1; k >= 0; k--) begin
            todos_zero   = todos_zero && (ativo_valor_prox[4*k +: 4] == 4'd0);
            suprimido[k] = apagar_zeros && (k > 0) && todos_zero;
        end
        anodos_d = '1;
        ponto_d  = 1'b1;
        digito_d = ativo_valor_prox[{idx_prox, 2'b00} +: 4];
        quadro_d = (estado_prox == EXIBE) && (idx_prox == IDX_ULT) && (cnt_prox == CNT_UM);
        if (estado_prox == EXIBE && !suprimido[idx_prox]) begin
            anodos_d[idx_prox] = 1'b0;
            ponto_d            = ~ativo_pontos_prox[idx_prox];
        end
    end
endmodule

// File: tb/tb_controlador_varredura_display.sv
// tb/tb_controlador_varredura_display.sv - table-driven bench for controlador_varredura_display
module tb_controlador_varredura_display;
    localparam int N     = 4;
    localparam int CE    = 4;
    localparam int CA    = 2;
    localparam int SLOT  = CA + CE;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset, habilita, carregar, apagar_zeros;
    logic [15:0] valor_in;
    logic [3:0]  pontos_in;
    logic [3:0]  digito_bcd;
    logic [3:0]  anodos;
    logic        ponto;
    logic [1:0]  indice;
    logic        quadro_fim;

    controlador_varredura_display #(
        .N_DIGITOS(N), .CICLOS_EXIBE(CE), .CICLOS_APAGA(CA)
    ) dut (
        .clk(clk), .reset(reset), .habilita(habilita), .carregar(carregar),
        .valor_in(valor_in), .pontos_in(pontos_in), .apagar_zeros(apagar_zeros),
        .digito_bcd(digito_bcd), .anodos(anodos), .ponto(ponto),
        .indice(indice), .quadro_fim(quadro_fim)
    );

    always #5 clk = ~clk;

    wire [11:0] obs = {anodos, ponto, digito_bcd, indice, quadro_fim};

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  pts;
        logic        apz;
        logic [3:0]  lit;
    } vec_t;
    vec_t tab [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // packed: anodos[11:8] ponto[7] digito[6:3] indice[2:1] quadro_fim[0]
    task automatic chk(input string nome, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got an=%b pt=%b dg=%h ix=%0d qf=%b required an=%b pt=%b dg=%h ix=%0d qf=%b",
                     nome, got[11:8], got[7], got[6:3], got[2:1], got[0],
                     exp[11:8], exp[7], exp[6:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic start(input logic [15:0] v, input logic [3:0] pt);
        habilita  = 1'b0;
        carregar  = 1'b1;
        valor_in  = v;
        pontos_in = pt;
        tick();
        carregar = 1'b0;
        habilita = 1'b1;
        tick();
    endtask

    // checks one full frame from its first APAGA cycle; optionally strobes carregar after cycle load_at
    task automatic frame_check(input string nome, input logic [15:0] val, input logic [3:0] lit,
                               input logic [3:0] pts, input int load_at, input logic [15:0] load_val);
        for (int f = 0; f < FRAME; f++) begin
            int s, p;
            logic [3:0] an, dg;
            logic pt, qf;
            s  = f / SLOT;
            p  = f % SLOT;
            an = 4'hF;
            pt = 1'b1;
            dg = val[4*s +: 4];
            qf = (s == N - 1) && (p == SLOT - 1);
            if (p >= CA && lit[s]) begin
                an[s] = 1'b0;
                pt    = ~pts[s];
            end
            chk($sformatf("%s c%0d", nome, f), obs, {an, pt, dg, 2'(s), qf});
            if (f == load_at) begin
                carregar = 1'b1;
                valor_in = load_val;
            end
            tick();
            carregar = 1'b0;
        end
    endtask

    initial begin
        tab[0] = '{val: 16'h12A7, pts: 4'b0100, apz: 1'b0, lit: 4'b1111};
        tab[1] = '{val: 16'h0050, pts: 4'b0000, apz: 1'b1, lit: 4'b0011};
        tab[2] = '{val: 16'h0000, pts: 4'b0001, apz: 1'b1, lit: 4'b0001};
        tab[3] = '{val: 16'h0000, pts: 4'b1111, apz: 1'b0, lit: 4'b1111};
        tab[4] = '{val: 16'h0050, pts: 4'b1111, apz: 1'b1, lit: 4'b0011};
        tab[5] = '{val: 16'hF00E, pts: 4'b0010, apz: 1'b1, lit: 4'b1111};
        tab[6] = '{val: 16'h0A00, pts: 4'b0000, apz: 1'b1, lit: 4'b0111};

        reset = 1'b1; habilita = 1'b0; carregar = 1'b0; apagar_zeros = 1'b0;
        valor_in = 16'h0; pontos_in = 4'h0;
        tick();
        tick();
        chk("reset state", obs, {4'hF, 1'b1, 4'h0, 2'd0, 1'b0});
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("idle %0d", i), obs, {4'hF, 1'b1, 4'h0, 2'd0, 1'b0});
        end

        for (int i = 0; i < 7; i++) begin
            apagar_zeros = tab[i].apz;
            start(tab[i].val, tab[i].pts);
            frame_check($sformatf("vec%0d f0", i), tab[i].val, tab[i].lit, tab[i].pts, -1, 16'h0);
            frame_check($sformatf("vec%0d f1", i), tab[i].val, tab[i].lit, tab[i].pts, -1, 16'h0);
        end

        // tear-free load: mid-frame and frame-start strobes
        apagar_zeros = 1'b0;
        start(16'h1111, 4'h0);
        frame_check("tear f1", 16'h1111, 4'hF, 4'h0, SLOT + CA, 16'h2222);
        frame_check("tear f2", 16'h2222, 4'hF, 4'h0, FRAME - 1, 16'h3333);
        frame_check("tear f3", 16'h2222, 4'hF, 4'h0, -1, 16'h0);
        frame_check("tear f4", 16'h3333, 4'hF, 4'h0, -1, 16'h0);

        // enable dropped during digit 2 EXIBE, then restarted
        start(16'h12A7, 4'b0100);
        for (int i = 0; i < 2 * SLOT + CA; i++) tick();
        chk("digit2 exibe", obs, {4'b1011, 1'b0, 4'h2, 2'd2, 1'b0});
        habilita = 1'b0;
        tick();
        chk("disable off", {anodos, ponto, indice}, {4'hF, 1'b1, 2'd0});
        tick();
        chk("disable hold", {anodos, ponto, indice, quadro_fim}, {4'hF, 1'b1, 2'd0, 1'b0});
        habilita = 1'b1;
        tick();
        frame_check("reenable", 16'h12A7, 4'hF, 4'b0100, -1, 16'h0);

        // reset asserted mid-EXIBE wins over habilita
        for (int i = 0; i < CA + 1; i++) tick();
        chk("pre-reset exibe", obs, {4'b1110, 1'b1, 4'h7, 2'd0, 1'b0});
        reset = 1'b1;
        tick();
        chk("reset mid-scan", obs, {4'hF, 1'b1, 4'h0, 2'd0, 1'b0});
        reset = 1'b0;
        habilita = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("post-reset idle %0d", i), obs, {4'hF, 1'b1, 4'h0, 2'd0, 1'b0});
        end

        // random stimulus: at most one anode low, >= CA dark cycles between different anodes
        begin
            int ultimo, gap, k, lows;
            ultimo = -1;
            gap    = 0;
            for (int c = 0; c < 10000; c++) begin
                habilita = ($urandom_range(0, 31) != 0);
                carregar = ($urandom_range(0, 3) == 0);
                valor_in = 16'($urandom) >> $urandom_range(0, 16);
                pontos_in = 4'($urandom);
                if ($urandom_range(0, 63) == 0) apagar_zeros = ~apagar_zeros;
                tick();
                lows = 0;
                k = 0;
                for (int j = 0; j < N; j++) if (!anodos[j]) begin lows++; k = j; end
                n_cmp++;
                if (lows > 1) begin
                    n_err++;
                    $display("FAIL onehot c%0d: got anodos=%b required at most one low", c, anodos);
                end
                if (lows == 1) begin
                    if (ultimo >= 0 && k != ultimo) begin
                        n_cmp++;
                        if (gap < CA) begin
                            n_err++;
                            $display("FAIL deadtime c%0d: got %0d dark cycles required >= %0d", c, gap, CA);
                        end
                    end
                    ultimo = k;
                    gap    = 0;
                end else begin
                    gap++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
